// File: rtl/geri_yazma_hakemi_pkg.sv
// Shared definitions for the writeback arbiter: producer encodings,
// default widths and the fixed-priority / alternating winner selection.
package geri_yazma_hakemi_pkg;

  localparam int XLEN_VARSAYILAN      = 32;
  localparam int ADRES_BIT_VARSAYILAN = 5;

  // Which producer owns the write port in a given cycle.
  typedef enum logic [1:0] {
    KAYNAK_YOK = 2'd0,
    KAYNAK_ALU = 2'd1,
    KAYNAK_BEL = 2'd2,
    KAYNAK_CB  = 2'd3
  } kaynak_t;

  // ALU always wins; load and mul/div alternate when both wait, the one
  // that did not win last time goes first.
  function automatic kaynak_t kazanan_sec(
    input logic    alu_v,
    input logic    bel_v,
    input logic    cb_v,
    input kaynak_t son
  );
    kaynak_t k;
    k = KAYNAK_YOK;
    if (alu_v) begin
      k = KAYNAK_ALU;
    end else if (bel_v && cb_v) begin
      if (son == KAYNAK_BEL) begin
        k = KAYNAK_CB;
      end else begin
        k = KAYNAK_BEL;
      end
    end else if (bel_v) begin
      k = KAYNAK_BEL;
    end else if (cb_v) begin
      k = KAYNAK_CB;
    end else begin
      k = KAYNAK_YOK;
    end
    return k;
  endfunction

endpackage

// File: rtl/geri_yazma_hakemi_puan_tablosu.sv
// Busy-register scoreboard: one flag per architectural register, set when
// decode issues a writer and cleared when the write port commits it.
module puan_tablosu
  import geri_yazma_hakemi_pkg::*;
#(
  parameter int ADRES_BIT = ADRES_BIT_VARSAYILAN
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 set_gecerli_i,
  input  logic [ADRES_BIT-1:0] set_adres_i,
  input  logic                 sil_gecerli_i,
  input  logic [ADRES_BIT-1:0] sil_adres_i,
  input  logic [ADRES_BIT-1:0] sorgu1_adres_i,
  input  logic [ADRES_BIT-1:0] sorgu2_adres_i,
  input  logic [ADRES_BIT-1:0] sorgu3_adres_i,
  output logic                 mesgul1_o,
  output logic                 mesgul2_o,
  output logic                 mesgul3_o
);

  localparam int DERINLIK = 2 ** ADRES_BIT;

  logic [DERINLIK-1:0] mesgul_q;
  logic [DERINLIK-1:0] mesgul_d;

  // Next busy vector: clear the committed register, then a same-cycle set wins; r0 never busy.
  always_comb begin
    mesgul_d = mesgul_q;
    for (int i = 0; i < DERINLIK; i++) begin
      if (set_gecerli_i && (set_adres_i == ADRES_BIT'(i))) begin
        mesgul_d[i] = 1'b1;
      end else if (sil_gecerli_i && (sil_adres_i == ADRES_BIT'(i))) begin
        mesgul_d[i] = 1'b0;
      end else begin
        mesgul_d[i] = mesgul_q[i];
      end
    end
    mesgul_d[0] = 1'b0;
  end

  // Busy vector register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mesgul_q <= {DERINLIK{1'b0}};
    end else begin
      mesgul_q <= mesgul_d;
    end
  end

  assign mesgul1_o = mesgul_q[sorgu1_adres_i];
  assign mesgul2_o = mesgul_q[sorgu2_adres_i];
  assign mesgul3_o = mesgul_q[sorgu3_adres_i];

endmodule

// File: rtl/geri_yazma_hakemi.sv
// Writeback arbiter: merges ALU, load and mul/div results onto the single
// register-file write port, drives hazard stalls and operand forwarding.
module geri_yazma_hakemi
  import geri_yazma_hakemi_pkg::*;
#(
  parameter int XLEN      = XLEN_VARSAYILAN,
  parameter int ADRES_BIT = ADRES_BIT_VARSAYILAN
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 isle_gecerli_i,
  input  logic [ADRES_BIT-1:0] isle_adres_i,
  input  logic                 alu_gecerli_i,
  input  logic [ADRES_BIT-1:0] alu_adres_i,
  input  logic [XLEN-1:0]      alu_deger_i,
  input  logic                 bel_gecerli_i,
  input  logic [ADRES_BIT-1:0] bel_adres_i,
  input  logic [XLEN-1:0]      bel_deger_i,
  output logic                 bel_hazir_o,
  input  logic                 cb_gecerli_i,
  input  logic [ADRES_BIT-1:0] cb_adres_i,
  input  logic [XLEN-1:0]      cb_deger_i,
  output logic                 cb_hazir_o,
  input  logic [ADRES_BIT-1:0] ky1_adres_i,
  input  logic [ADRES_BIT-1:0] ky2_adres_i,
  output logic                 ky1_mesgul_o,
  output logic                 ky2_mesgul_o,
  output logic                 hy_mesgul_o,
  output logic                 ky1_ileri_o,
  output logic                 ky2_ileri_o,
  output logic [XLEN-1:0]      ky_ileri_deger_o,
  output logic                 yaz_o,
  output logic [ADRES_BIT-1:0] hy_adres_o,
  output logic [XLEN-1:0]      hy_deger_o
);

  localparam logic [ADRES_BIT-1:0] SIFIR_ADRES = {ADRES_BIT{1'b0}};

  kaynak_t                secim;
  kaynak_t                son_kazanan_q, son_kazanan_d;
  logic                   yaz_q, yaz_d;
  logic [ADRES_BIT-1:0]   hy_adres_q, hy_adres_d;
  logic [XLEN-1:0]        hy_deger_q, hy_deger_d;
  logic                   ky1_mesgul_ham, ky2_mesgul_ham, isle_mesgul_ham;

  // Pick this cycle's winner; nothing is accepted while reset is held.
  always_comb begin
    if (rst_i) begin
      secim = KAYNAK_YOK;
    end else begin
      secim = kazanan_sec(alu_gecerli_i, bel_gecerli_i, cb_gecerli_i, son_kazanan_q);
    end
  end

  assign bel_hazir_o = (secim == KAYNAK_BEL);
  assign cb_hazir_o  = (secim == KAYNAK_CB);

  // Next write-port contents; r0 completes its handshake without a write enable.
  always_comb begin
    son_kazanan_d = son_kazanan_q;
    yaz_d         = 1'b0;
    hy_adres_d    = hy_adres_q;
    hy_deger_d    = hy_deger_q;
    case (secim)
      KAYNAK_ALU: begin
        yaz_d      = (alu_adres_i != SIFIR_ADRES);
        hy_adres_d = alu_adres_i;
        hy_deger_d = alu_deger_i;
      end
      KAYNAK_BEL: begin
        yaz_d         = (bel_adres_i != SIFIR_ADRES);
        hy_adres_d    = bel_adres_i;
        hy_deger_d    = bel_deger_i;
        son_kazanan_d = KAYNAK_BEL;
      end
      KAYNAK_CB: begin
        yaz_d         = (cb_adres_i != SIFIR_ADRES);
        hy_adres_d    = cb_adres_i;
        hy_deger_d    = cb_deger_i;
        son_kazanan_d = KAYNAK_CB;
      end
      default: begin
        yaz_d = 1'b0;
      end
    endcase
  end

  // Write-port and last-winner registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      yaz_q         <= 1'b0;
      hy_adres_q    <= SIFIR_ADRES;
      hy_deger_q    <= {XLEN{1'b0}};
      son_kazanan_q <= KAYNAK_CB;
    end else begin
      yaz_q         <= yaz_d;
      hy_adres_q    <= hy_adres_d;
      hy_deger_q    <= hy_deger_d;
      son_kazanan_q <= son_kazanan_d;
    end
  end

  puan_tablosu #(
    .ADRES_BIT (ADRES_BIT)
  ) u_puan_tablosu (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .set_gecerli_i  (isle_gecerli_i),
    .set_adres_i    (isle_adres_i),
    .sil_gecerli_i  (yaz_q),
    .sil_adres_i    (hy_adres_q),
    .sorgu1_adres_i (ky1_adres_i),
    .sorgu2_adres_i (ky2_adres_i),
    .sorgu3_adres_i (isle_adres_i),
    .mesgul1_o      (ky1_mesgul_ham),
    .mesgul2_o      (ky2_mesgul_ham),
    .mesgul3_o      (isle_mesgul_ham)
  );

  // Forwarding and stall decisions against the write currently committing.
  always_comb begin
    ky1_ileri_o  = yaz_q && (hy_adres_q == ky1_adres_i) && (ky1_adres_i != SIFIR_ADRES);
    ky2_ileri_o  = yaz_q && (hy_adres_q == ky2_adres_i) && (ky2_adres_i != SIFIR_ADRES);
    ky1_mesgul_o = ky1_mesgul_ham && !ky1_ileri_o;
    ky2_mesgul_o = ky2_mesgul_ham && !ky2_ileri_o;
    hy_mesgul_o  = isle_mesgul_ham && !(yaz_q && (hy_adres_q == isle_adres_i));
  end

  assign yaz_o            = yaz_q;
  assign hy_adres_o       = hy_adres_q;
  assign hy_deger_o       = hy_deger_q;
  assign ky_ileri_deger_o = hy_deger_q;

endmodule

// File: tb/tb_geri_yazma_hakemi.sv
// Self-checking bench for geri_yazma_hakemi: directed vector table followed
// by randomized traffic compared against a behavioural reference model.
module tb_geri_yazma_hakemi;

  localparam int XLEN = 32;
  localparam int AB   = 5;
  localparam bit H    = 1'b1;
  localparam bit L    = 1'b0;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            isle_gecerli_i;
  logic [AB-1:0]   isle_adres_i;
  logic            alu_gecerli_i;
  logic [AB-1:0]   alu_adres_i;
  logic [XLEN-1:0] alu_deger_i;
  logic            bel_gecerli_i;
  logic [AB-1:0]   bel_adres_i;
  logic [XLEN-1:0] bel_deger_i;
  logic            bel_hazir_o;
  logic            cb_gecerli_i;
  logic [AB-1:0]   cb_adres_i;
  logic [XLEN-1:0] cb_deger_i;
  logic            cb_hazir_o;
  logic [AB-1:0]   ky1_adres_i;
  logic [AB-1:0]   ky2_adres_i;
  logic            ky1_mesgul_o, ky2_mesgul_o, hy_mesgul_o;
  logic            ky1_ileri_o, ky2_ileri_o;
  logic [XLEN-1:0] ky_ileri_deger_o;
  logic            yaz_o;
  logic [AB-1:0]   hy_adres_o;
  logic [XLEN-1:0] hy_deger_o;

  always #5 clk = ~clk;

  geri_yazma_hakemi #(.XLEN(XLEN), .ADRES_BIT(AB)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .isle_gecerli_i(isle_gecerli_i), .isle_adres_i(isle_adres_i),
    .alu_gecerli_i(alu_gecerli_i), .alu_adres_i(alu_adres_i), .alu_deger_i(alu_deger_i),
    .bel_gecerli_i(bel_gecerli_i), .bel_adres_i(bel_adres_i), .bel_deger_i(bel_deger_i),
    .bel_hazir_o(bel_hazir_o),
    .cb_gecerli_i(cb_gecerli_i), .cb_adres_i(cb_adres_i), .cb_deger_i(cb_deger_i),
    .cb_hazir_o(cb_hazir_o),
    .ky1_adres_i(ky1_adres_i), .ky2_adres_i(ky2_adres_i),
    .ky1_mesgul_o(ky1_mesgul_o), .ky2_mesgul_o(ky2_mesgul_o), .hy_mesgul_o(hy_mesgul_o),
    .ky1_ileri_o(ky1_ileri_o), .ky2_ileri_o(ky2_ileri_o),
    .ky_ileri_deger_o(ky_ileri_deger_o),
    .yaz_o(yaz_o), .hy_adres_o(hy_adres_o), .hy_deger_o(hy_deger_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk1(input string ad, input logic gercek, input logic beklenen);
    n_vec++;
    if (gercek !== beklenen) begin
      n_err++;
      $display("FAIL %s at %0t: got %b, expected %b", ad, $time, gercek, beklenen);
    end
  endtask

  task automatic chkw(input string ad, input logic [XLEN-1:0] gercek, input logic [XLEN-1:0] beklenen);
    n_vec++;
    if (gercek !== beklenen) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", ad, $time, gercek, beklenen);
    end
  endtask

  function automatic logic [AB-1:0] a(input int n);
    return AB'(n);
  endfunction

  function automatic logic [XLEN-1:0] d(input int n);
    return XLEN'(n);
  endfunction

  // ---------------- behavioural reference model ----------------
  // Register file view: which registers have a write outstanding, what the
  // write port shows now, and which of load/mul-div was served last.
  bit              m_busy [0:(2**AB)-1];
  bit              m_yaz;
  logic [AB-1:0]   m_adr;
  logic [XLEN-1:0] m_deg;
  int              m_son;  // 2 = load served last, 3 = mul/div served last

  bit p_belh, p_cbh, p_k1m, p_k1i, p_k2m, p_k2i, p_hym;

  // 0 none, 1 ALU, 2 load, 3 mul/div
  function automatic int winner();
    if (rst_i) return 0;
    if (alu_gecerli_i) return 1;
    if (bel_gecerli_i && cb_gecerli_i) return (m_son == 2) ? 3 : 2;
    if (bel_gecerli_i) return 2;
    if (cb_gecerli_i) return 3;
    return 0;
  endfunction

  task automatic model_predict();
    int w;
    w      = winner();
    p_belh = (w == 2);
    p_cbh  = (w == 3);
    p_k1i  = m_yaz && (m_adr == ky1_adres_i) && (ky1_adres_i != 0);
    p_k2i  = m_yaz && (m_adr == ky2_adres_i) && (ky2_adres_i != 0);
    p_k1m  = m_busy[ky1_adres_i] && !p_k1i;
    p_k2m  = m_busy[ky2_adres_i] && !p_k2i;
    p_hym  = m_busy[isle_adres_i] && !(m_yaz && (m_adr == isle_adres_i));
  endtask

  task automatic model_step();
    int w;
    if (rst_i) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_yaz = 1'b0;
      m_adr = '0;
      m_deg = '0;
      m_son = 3;
    end else begin
      w = winner();
      if (m_yaz) m_busy[m_adr] = 1'b0;
      if (isle_gecerli_i && isle_adres_i != 0) m_busy[isle_adres_i] = 1'b1;
      m_yaz = 1'b0;
      if (w == 1) begin
        m_yaz = (alu_adres_i != 0); m_adr = alu_adres_i; m_deg = alu_deger_i;
      end else if (w == 2) begin
        m_yaz = (bel_adres_i != 0); m_adr = bel_adres_i; m_deg = bel_deger_i; m_son = 2;
      end else if (w == 3) begin
        m_yaz = (cb_adres_i != 0); m_adr = cb_adres_i; m_deg = cb_deger_i; m_son = 3;
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst; bit iv; logic [AB-1:0] ia;
    bit av; logic [AB-1:0] aa; logic [XLEN-1:0] ad;
    bit bv; logic [AB-1:0] ba; logic [XLEN-1:0] bd;
    bit cv; logic [AB-1:0] ca; logic [XLEN-1:0] cd;
    logic [AB-1:0] k1; logic [AB-1:0] k2;
    bit belh; bit cbh; bit yaz; logic [AB-1:0] adr; logic [XLEN-1:0] deg;
    bit k1m; bit k1i; bit k2m; bit k2i; bit hym;
  } vek_t;

  vek_t vt[$];

  task automatic drive_vec(input vek_t v);
    rst_i = v.rst; isle_gecerli_i = v.iv; isle_adres_i = v.ia;
    alu_gecerli_i = v.av; alu_adres_i = v.aa; alu_deger_i = v.ad;
    bel_gecerli_i = v.bv; bel_adres_i = v.ba; bel_deger_i = v.bd;
    cb_gecerli_i = v.cv; cb_adres_i = v.ca; cb_deger_i = v.cd;
    ky1_adres_i = v.k1; ky2_adres_i = v.k2;
  endtask

  initial begin
    // rst iv ia | av aa ad | bv ba bd | cv ca cd | k1 k2 || belh cbh yaz adr deg | k1m k1i k2m k2i hym
    vt.push_back('{H,H,a(7), H,a(5),d('h1111), H,a(3),d('hAA), H,a(4),d('hBB), a(7),a(3), L,L,L,a(0),d(0), L,L,L,L,L});
    vt.push_back('{H,H,a(7), H,a(5),d('h1111), H,a(3),d('hAA), H,a(4),d('hBB), a(7),a(3), L,L,L,a(0),d(0), L,L,L,L,L});
    vt.push_back('{L,L,a(0), H,a(5),d('h1234), L,a(0),d(0),    L,a(0),d(0),    a(5),a(0), L,L,L,a(0),d(0), L,L,L,L,L});
    vt.push_back('{L,L,a(0), L,a(0),d(0),      L,a(0),d(0),    L,a(0),d(0),    a(5),a(5), L,L,H,a(5),d('h1234), L,H,L,H,L});
    vt.push_back('{L,L,a(0), L,a(0),d(0),      H,a(3),d('hAA), H,a(4),d('hBB), a(0),a(0), H,L,L,a(5),d('h1234), L,L,L,L,L});
    vt.push_back('{L,L,a(0), L,a(0),d(0),      H,a(6),d('hCC), H,a(4),d('hBB), a(3),a(0), L,H,H,a(3),d('hAA), L,H,L,L,L});
    vt.push_back('{L,L,a(0), H,a(8),d('h88),   H,a(6),d('hCC), L,a(0),d(0),    a(0),a(4), L,L,H,a(4),d('hBB), L,L,L,H,L});
    vt.push_back('{L,L,a(0), H,a(9),d('h99),   H,a(6),d('hCC), L,a(0),d(0),    a(0),a(0), L,L,H,a(8),d('h88), L,L,L,L,L});
    vt.push_back('{L,L,a(0), H,a(10),d('hA0),  H,a(6),d('hCC), L,a(0),d(0),    a(0),a(0), L,L,H,a(9),d('h99), L,L,L,L,L});
    vt.push_back('{L,L,a(0), L,a(0),d(0),      H,a(6),d('hCC), L,a(0),d(0),    a(0),a(0), H,L,H,a(10),d('hA0), L,L,L,L,L});
    vt.push_back('{L,H,a(7), L,a(0),d(0),      L,a(0),d(0),    L,a(0),d(0),    a(7),a(0), L,L,H,a(6),d('hCC), L,L,L,L,L});
    vt.push_back('{L,L,a(0), L,a(0),d(0),      L,a(0),d(0),    L,a(0),d(0),    a(7),a(7), L,L,L,a(6),d('hCC), H,L,H,L,L});
    vt.push_back('{L,L,a(0), H,a(7),d('h77),   L,a(0),d(0),    L,a(0),d(0),    a(7),a(0), L,L,L,a(6),d('hCC), H,L,L,L,L});
    vt.push_back('{L,L,a(0), L,a(0),d(0),      L,a(0),d(0),    L,a(0),d(0),    a(7),a(7), L,L,H,a(7),d('h77), L,H,L,H,L});
    vt.push_back('{L,L,a(0), L,a(0),d(0),      L,a(0),d(0),    L,a(0),d(0),    a(7),a(0), L,L,L,a(7),d('h77), L,L,L,L,L});
    vt.push_back('{L,L,a(0), L,a(0),d(0),      L,a(0),d(0),    H,a(0),d('hFF), a(0),a(0), L,H,L,a(7),d('h77), L,L,L,L,L});
    vt.push_back('{L,H,a(0), L,a(0),d(0),      L,a(0),d(0),    L,a(0),d(0),    a(0),a(0), L,L,L,a(0),d('hFF), L,L,L,L,L});
    vt.push_back('{L,L,a(0), L,a(0),d(0),      L,a(0),d(0),    L,a(0),d(0),    a(0),a(0), L,L,L,a(0),d('hFF), L,L,L,L,L});
    vt.push_back('{L,L,a(0), H,a(5),d('h55),   L,a(0),d(0),    L,a(0),d(0),    a(0),a(0), L,L,L,a(0),d('hFF), L,L,L,L,L});
    vt.push_back('{L,H,a(5), L,a(0),d(0),      L,a(0),d(0),    L,a(0),d(0),    a(5),a(0), L,L,H,a(5),d('h55), L,H,L,L,L});
    vt.push_back('{L,L,a(5), L,a(0),d(0),      L,a(0),d(0),    L,a(0),d(0),    a(5),a(0), L,L,L,a(5),d('h55), H,L,L,L,H});
    vt.push_back('{L,L,a(5), H,a(5),d('h56),   L,a(0),d(0),    L,a(0),d(0),    a(5),a(0), L,L,L,a(5),d('h55), H,L,L,L,H});
    vt.push_back('{L,L,a(5), L,a(0),d(0),      L,a(0),d(0),    L,a(0),d(0),    a(5),a(0), L,L,H,a(5),d('h56), L,H,L,L,L});
    vt.push_back('{L,H,a(9), L,a(0),d(0),      L,a(0),d(0),    L,a(0),d(0),    a(9),a(0), L,L,L,a(5),d('h56), L,L,L,L,L});
    vt.push_back('{H,L,a(0), L,a(0),d(0),      H,a(2),d('h22), L,a(0),d(0),    a(9),a(0), L,L,L,a(5),d('h56), H,L,L,L,L});
    vt.push_back('{L,L,a(0), L,a(0),d(0),      L,a(0),d(0),    L,a(0),d(0),    a(9),a(0), L,L,L,a(0),d(0),    L,L,L,L,L});

    // Reset preamble: one edge with reset held and every producer valid.
    drive_vec(vt[0]);
    @(posedge clk);
    model_step();

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      drive_vec(vt[i]);
      #1;
      chk1($sformatf("v%0d bel_hazir", i), bel_hazir_o, vt[i].belh);
      chk1($sformatf("v%0d cb_hazir", i), cb_hazir_o, vt[i].cbh);
      chk1($sformatf("v%0d yaz", i), yaz_o, vt[i].yaz);
      chkw($sformatf("v%0d hy_adres", i), XLEN'(hy_adres_o), XLEN'(vt[i].adr));
      chkw($sformatf("v%0d hy_deger", i), hy_deger_o, vt[i].deg);
      chkw($sformatf("v%0d ileri_deger", i), ky_ileri_deger_o, vt[i].deg);
      chk1($sformatf("v%0d ky1_mesgul", i), ky1_mesgul_o, vt[i].k1m);
      chk1($sformatf("v%0d ky1_ileri", i), ky1_ileri_o, vt[i].k1i);
      chk1($sformatf("v%0d ky2_mesgul", i), ky2_mesgul_o, vt[i].k2m);
      chk1($sformatf("v%0d ky2_ileri", i), ky2_ileri_o, vt[i].k2i);
      chk1($sformatf("v%0d hy_mesgul", i), hy_mesgul_o, vt[i].hym);
      @(posedge clk);
      model_step();
    end

    // Randomized traffic against the reference model; decode only issues when no stall.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_i          = ($urandom_range(63) == 0);
      alu_gecerli_i  = ($urandom_range(3) == 0);
      alu_adres_i    = AB'($urandom_range(7));
      alu_deger_i    = $urandom;
      bel_gecerli_i  = ($urandom_range(1) == 0);
      bel_adres_i    = AB'($urandom_range(7));
      bel_deger_i    = $urandom;
      cb_gecerli_i   = ($urandom_range(1) == 0);
      cb_adres_i     = AB'($urandom_range(7));
      cb_deger_i     = $urandom;
      ky1_adres_i    = AB'($urandom_range(7));
      ky2_adres_i    = AB'($urandom_range(7));
      isle_adres_i   = AB'($urandom_range(7));
      model_predict();
      isle_gecerli_i = ($urandom_range(1) == 0) && !p_k1m && !p_k2m && !p_hym;
      #1;
      chk1("r bel_hazir", bel_hazir_o, p_belh);
      chk1("r cb_hazir", cb_hazir_o, p_cbh);
      chk1("r yaz", yaz_o, m_yaz);
      chkw("r hy_adres", XLEN'(hy_adres_o), XLEN'(m_adr));
      chkw("r hy_deger", hy_deger_o, m_deg);
      chkw("r ileri_deger", ky_ileri_deger_o, m_deg);
      chk1("r ky1_mesgul", ky1_mesgul_o, p_k1m);
      chk1("r ky1_ileri", ky1_ileri_o, p_k1i);
      chk1("r ky2_mesgul", ky2_mesgul_o, p_k2m);
      chk1("r ky2_ileri", ky2_ileri_o, p_k2i);
      chk1("r hy_mesgul", hy_mesgul_o, p_hym);
      @(posedge clk);
      model_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
